// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - valid/ready operand and result bundle for the EX-stage ALU
interface alu_pipe_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ctl;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [WIDTH-1:0] out_hi;
   logic             out_zero;
   logic             out_err;

   modport master (
      output in_valid, ctl, shamt, data_a, data_b, out_ready,
      input  in_ready, out_valid, out_data, out_hi, out_zero, out_err
   );

   modport slave (
      input  in_valid, ctl, shamt, data_a, data_b, out_ready,
      output in_ready, out_valid, out_data, out_hi, out_zero, out_err
   );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - execute-stage ALU, registered result, valid/ready on both sides
// Single-cycle ops complete at accept; multu runs a WIDTH-step shift-add then a DONE load cycle.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SRL   = 4'b0011;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SRA   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_XOR   = 4'b1000;
   localparam logic [3:0] OP_NOR   = 4'b1001;
   localparam logic [3:0] OP_SLTU  = 4'b1010;
   localparam logic [3:0] OP_MULTU = 4'b1100;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next;
   logic [SHW-1:0]     r_cnt;
   logic [2*WIDTH-1:0] r_mc;
   logic [WIDTH-1:0]   r_mp;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic [WIDTH-1:0]   r_out_hi;
   logic               r_out_zero;
   logic               r_out_err;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_is_mul;
   logic [WIDTH:0]     w_diff;
   logic               w_ovf;
   logic               w_slt;
   logic [WIDTH-1:0]   w_res;
   logic               w_err;

   assign w_is_mul = (bus.ctl == OP_MULTU);

   // Extra top bit of the difference is the unsigned borrow used by sltu.
   assign w_diff = {1'b0, bus.data_a} - {1'b0, bus.data_b};
   assign w_ovf  = (bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1]) &
                   (w_diff[WIDTH-1] ^ bus.data_a[WIDTH-1]);
   assign w_slt  = w_diff[WIDTH-1] ^ w_ovf;

   always_comb begin
      w_res = '0;
      w_err = 1'b0;
      case (bus.ctl)
         OP_AND:   w_res = bus.data_a & bus.data_b;
         OP_OR:    w_res = bus.data_a | bus.data_b;
         OP_ADD:   w_res = bus.data_a + bus.data_b;
         OP_SUB:   w_res = w_diff[WIDTH-1:0];
         OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_slt};
         OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
         OP_SRL:   w_res = bus.data_a >> bus.shamt;
         OP_SLL:   w_res = bus.data_a << bus.shamt;
         OP_SRA:   w_res = $signed(bus.data_a) >>> bus.shamt;
         OP_XOR:   w_res = bus.data_a ^ bus.data_b;
         OP_NOR:   w_res = ~(bus.data_a | bus.data_b);
         OP_MULTU: w_res = '0;
         default:  w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_is_mul) w_next = S_MUL;
         S_MUL:   if (r_cnt == CNT_LAST) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
      w_accept   = w_in_ready && bus.in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_mc        <= '0;
         r_mp        <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_hi    <= '0;
         r_out_zero  <= 1'b1;
         r_out_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_mc  <= {{WIDTH{1'b0}}, bus.data_a};
                  r_mp  <= bus.data_b;
                  r_acc <= '0;
                  r_cnt <= '0;
               end
            end
            S_MUL: begin
               if (r_mp[0]) r_acc <= r_acc + r_mc;
               r_mc  <= r_mc << 1;
               r_mp  <= r_mp >> 1;
               r_cnt <= r_cnt + SHW'(1);
            end
            default: ;
         endcase

         // A pending result always drains before multu is accepted, so DONE never overwrites one.
         if (r_state == S_DONE) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc[WIDTH-1:0];
            r_out_hi    <= r_acc[2*WIDTH-1:WIDTH];
            r_out_zero  <= (r_acc[WIDTH-1:0] == '0);
            r_out_err   <= 1'b0;
         end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_out_hi    <= '0;
            r_out_zero  <= (w_res == '0);
            r_out_err   <= w_err;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_hi    = r_out_hi;
   assign bus.out_zero  = r_out_zero;
   assign bus.out_err   = r_out_err;
endmodule
